// File: rtl/vlg_pulse_pkg.sv
// Shared definitions for the vlg_pulse_gen pulse transmitter.
//   pulse_state_e : FSM state encoding (idle, pulse high phase, enforced low gap).
//   MIN_WIDTH     : the smallest pulse width the generator emits; a requested width of 0
//                   is promoted to this value.
//   eff_width()   : maps a requested width to the effective width (0 -> MIN_WIDTH).
package vlg_pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } pulse_state_e;

  localparam int unsigned MIN_WIDTH = 1;

  function automatic int unsigned eff_width(input int unsigned width);
    return (width == 0) ? MIN_WIDTH : width;
  endfunction

endpackage

// File: rtl/vlg_pulse_cnt.sv
// Loadable down-counter used for both the high phase and the low gap of a pulse.
// Ports:
//   i_clk       clock, rising edge
//   i_rst_n     synchronous active-low reset, clears the count
//   i_load      load i_load_val (has priority over i_en)
//   i_load_val  value to load
//   i_en        decrement by one; the count saturates at zero and never wraps
//   o_tc        terminal count: the count currently reads 1 (last cycle of the phase)
module vlg_pulse_cnt
  import vlg_pulse_pkg::*;
#(
  parameter int unsigned CNT_BITS = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_load,
  input  logic [CNT_BITS-1:0] i_load_val,
  input  logic                i_en,
  output logic                o_tc
);

  logic [CNT_BITS-1:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (i_load) begin
      cnt_q <= i_load_val;
    end else if (i_en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_BITS'(1);
    end
  end

  assign o_tc = (cnt_q == CNT_BITS'(MIN_WIDTH));

endmodule

// File: rtl/vlg_pulse_gen.sv
// Pulse transmitter: turns a one-cycle trigger into a clean pulse of programmable width
// followed by a guaranteed low gap. All outputs are registered.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  synchronous active-low reset
//   i_trig   trigger request, sampled every cycle
//   i_width  pulse high length in cycles (0 acts as 1), captured when a trigger is accepted
//   o_pulse  generated pulse
//   o_busy   high while a pulse or its low gap is in progress
//   o_done   one-cycle strobe on the first low cycle after a pulse
//   o_drop   one-cycle strobe: the previous cycle's trigger was rejected
// Build option: define VLG_PULSE_RETRIG_EN to let a trigger during the high phase reload the
// width and extend the pulse; triggers during the gap are still rejected.
module vlg_pulse_gen
  import vlg_pulse_pkg::*;
#(
  parameter int unsigned WIDTH_BITS = 8,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_trig,
  input  logic [WIDTH_BITS-1:0] i_width,
  output logic                  o_pulse,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_drop
);

  // A zero-length gap still needs a legal (unused) counter width.
  localparam int unsigned GAP_BITS = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

`ifdef VLG_PULSE_RETRIG_EN
  localparam bit RETRIG_EN = 1'b1;
`else
  localparam bit RETRIG_EN = 1'b0;
`endif

  pulse_state_e state_q;
  logic         pulse_q, busy_q, done_q, drop_q;

  logic [WIDTH_BITS-1:0] eff_w;
  logic [WIDTH_BITS-1:0] high_load_val;
  logic in_idle, in_high, in_gap;
  logic retrig, high_exit, gap_last, accept, drop_req;
  logic high_load, high_en, high_tc;
  logic gap_load, gap_en, gap_tc;

  assign eff_w = WIDTH_BITS'(eff_width(32'(i_width)));

  always_comb begin
    in_idle  = (state_q == ST_IDLE);
    in_high  = (state_q == ST_HIGH);
    in_gap   = (state_q == ST_GAP);
    retrig   = RETRIG_EN && i_trig && in_high;
    // A retrigger whose new width is 1 ends the pulse on this very edge.
    high_exit = retrig ? (eff_w == WIDTH_BITS'(MIN_WIDTH)) : high_tc;
    // The edge that ends the gap behaves like idle, so the low time is exactly GAP_CYCLES.
    gap_last = in_gap && gap_tc;
    accept   = i_trig && (in_idle || gap_last);
    drop_req = i_trig && !accept && !retrig && !in_idle;

    high_load = accept || (retrig && !high_exit);
    // On a retrigger the current edge already counts as the first of the new width.
    high_load_val = retrig ? (eff_w - WIDTH_BITS'(1)) : eff_w;
    high_en   = in_high && !retrig && !high_exit;

    gap_load = in_high && high_exit && (GAP_CYCLES != 0);
    gap_en   = in_gap && !gap_tc;
  end

  vlg_pulse_cnt #(
    .CNT_BITS (WIDTH_BITS)
  ) u_high_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (high_load),
    .i_load_val (high_load_val),
    .i_en       (high_en),
    .o_tc       (high_tc)
  );

  vlg_pulse_cnt #(
    .CNT_BITS (GAP_BITS)
  ) u_gap_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (gap_load),
    .i_load_val (GAP_BITS'(GAP_CYCLES)),
    .i_en       (gap_en),
    .o_tc       (gap_tc)
  );

  // Outputs are registered from the state, so the pulse appears one edge after acceptance.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      pulse_q <= in_high;
      busy_q  <= !in_idle;
      done_q  <= pulse_q && !in_high;
      drop_q  <= drop_req;
      case (state_q)
        ST_IDLE: if (accept) state_q <= ST_HIGH;
        ST_HIGH: if (high_exit) state_q <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        ST_GAP:  if (gap_tc) state_q <= accept ? ST_HIGH : ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_pulse = pulse_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_drop  = drop_q;

endmodule

// File: tb/tb_vlg_pulse_gen.sv
// Bench for vlg_pulse_gen: two instances (GAP_CYCLES=2 and GAP_CYCLES=0) share the same
// stimulus. The reference model tracks the pulse as a timeline of absolute edge numbers
// (accept edge, last high edge, earliest next-accept edge) and derives every output from it.
module tb_vlg_pulse_gen;

  localparam int unsigned WB = 8;
`ifdef VLG_PULSE_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_trig = 1'b0;
  logic [WB-1:0] i_width = '0;
  logic          pulse_a, busy_a, done_a, drop_a;
  logic          pulse_b, busy_b, done_b, drop_b;

  logic [3:0] obs [2];
  logic [3:0] exp_out [2];
  int         checks = 0;
  int         failures = 0;
  longint     cyc = 0;
  longint     m_acc [2];
  longint     m_hi [2];
  longint     m_ok [2];
  int         gaps [2] = '{2, 0};

  vlg_pulse_gen #(.WIDTH_BITS(WB), .GAP_CYCLES(2)) dut_gap2 (
    .i_clk (i_clk), .i_rst_n (i_rst_n), .i_trig (i_trig), .i_width (i_width),
    .o_pulse (pulse_a), .o_busy (busy_a), .o_done (done_a), .o_drop (drop_a)
  );

  vlg_pulse_gen #(.WIDTH_BITS(WB), .GAP_CYCLES(0)) dut_gap0 (
    .i_clk (i_clk), .i_rst_n (i_rst_n), .i_trig (i_trig), .i_width (i_width),
    .o_pulse (pulse_b), .o_busy (busy_b), .o_done (done_b), .o_drop (drop_b)
  );

  always #5 i_clk = ~i_clk;

  always_comb begin
    obs[0] = {pulse_a, busy_a, done_a, drop_a};
    obs[1] = {pulse_b, busy_b, done_b, drop_b};
  end

  // Outputs registered at edge e, from the timeline as it stood before edge e.
  task automatic model_edge(input int d, input logic rst_v, input logic trig_v,
                            input logic [WB-1:0] w_v);
    longint e, g, w, low;
    logic   p, b, dn, rt, acc, dr;
    e   = cyc;
    g   = longint'(gaps[d]);
    w   = (w_v == 0) ? 64'sd1 : longint'(w_v);
    low = (g > 0) ? g : 64'sd1;
    if (!rst_v) begin
      exp_out[d] = 4'b0000;
      m_acc[d]   = -10;
      m_hi[d]    = -10;
      m_ok[d]    = e + 1;
    end else begin
      p   = (e > m_acc[d]) && (e <= m_hi[d]);
      b   = (e > m_acc[d]) && (e <= m_hi[d] + g);
      dn  = (e == m_hi[d] + 1);
      rt  = RETRIG && trig_v && p;
      acc = trig_v && (e >= m_ok[d]);
      dr  = trig_v && !acc && !rt && (e > m_acc[d]) && (e < m_ok[d]);
      exp_out[d] = {p, b, dn, dr};
      if (acc) begin
        m_acc[d] = e;
        m_hi[d]  = e + w;
        m_ok[d]  = m_hi[d] + low;
      end else if (rt) begin
        m_hi[d] = e + w - 1;
        m_ok[d] = m_hi[d] + low;
      end
    end
  endtask

  task automatic tick(input logic rst_v, input logic trig_v, input logic [WB-1:0] w_v);
    i_rst_n = rst_v;
    i_trig  = trig_v;
    i_width = w_v;
    @(posedge i_clk);
    for (int d = 0; d < 2; d++) model_edge(d, rst_v, trig_v, w_v);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 13; i++) begin
      tick(i >= 3, i == 1, 8'd4);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_out[d]) begin
          failures++;
          $display("FAIL reset gap%0d cyc %0d: pulse/busy/done/drop got %b want %b",
                   gaps[d], cyc, obs[d], exp_out[d]);
        end
      end
    end
  endtask

  task automatic test_single_pulse();
    int len = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, i == 0, 8'd5);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_out[d]) begin
          failures++;
          $display("FAIL single_pulse gap%0d cyc %0d: pulse/busy/done/drop got %b want %b",
                   gaps[d], cyc, obs[d], exp_out[d]);
        end
      end
      if (pulse_a) len++;
    end
    checks++;
    if (len != 5) begin
      failures++;
      $display("FAIL single_pulse length: got %0d want 5", len);
    end
  endtask

  task automatic test_width_bounds();
    logic [WB-1:0] ws [2];
    int            want [2];
    ws[0] = 8'd0;   want[0] = 1;
    ws[1] = 8'd255; want[1] = 255;
    for (int k = 0; k < 2; k++) begin
      int len [2];
      len[0] = 0;
      len[1] = 0;
      // Width is scrambled after the trigger; it must not affect the running pulse.
      for (int j = 0; j < want[k] + 8; j++) begin
        tick(1'b1, j == 0, (j == 0) ? ws[k] : WB'($urandom));
        for (int d = 0; d < 2; d++) begin
          checks++;
          if (obs[d] !== exp_out[d]) begin
            failures++;
            $display("FAIL width_bounds gap%0d cyc %0d: pulse/busy/done/drop got %b want %b",
                     gaps[d], cyc, obs[d], exp_out[d]);
          end
        end
        if (pulse_a) len[0]++;
        if (pulse_b) len[1]++;
      end
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (len[d] != want[k]) begin
          failures++;
          $display("FAIL width_bounds length gap%0d: got %0d want %0d", gaps[d], len[d],
                   want[k]);
        end
      end
    end
  endtask

  task automatic test_trig_in_high();
    int len = 0;
    int want;
    want = RETRIG ? 8 : 5;
    for (int j = 0; j < 16; j++) begin
      tick(1'b1, (j == 0) || (j == 4), 8'd5);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_out[d]) begin
          failures++;
          $display("FAIL trig_in_high gap%0d cyc %0d: pulse/busy/done/drop got %b want %b",
                   gaps[d], cyc, obs[d], exp_out[d]);
        end
      end
      if (j == 4) begin
        checks++;
        if (drop_a !== !RETRIG) begin
          failures++;
          $display("FAIL trig_in_high drop: got %b want %b", drop_a, !RETRIG);
        end
      end
      if (pulse_a) len++;
    end
    checks++;
    if (len != want) begin
      failures++;
      $display("FAIL trig_in_high length: got %0d want %0d", len, want);
    end
  endtask

  task automatic test_held_trig();
    for (int j = 0; j < 30; j++) begin
      tick(1'b1, 1'b1, 8'd3);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_out[d]) begin
          failures++;
          $display("FAIL held_trig gap%0d cyc %0d: pulse/busy/done/drop got %b want %b",
                   gaps[d], cyc, obs[d], exp_out[d]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    int len [2];
    len[0] = 0;
    len[1] = 0;
    for (int j = 0; j < 34; j++) begin
      // Idle 6, trigger at 6, reset at pulse cycle 2, fresh trigger after release.
      tick(j != 9, (j == 6) || (j == 11), 8'd10);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_out[d]) begin
          failures++;
          $display("FAIL reset_mid_pulse gap%0d cyc %0d: pulse/busy/done/drop got %b want %b",
                   gaps[d], cyc, obs[d], exp_out[d]);
        end
      end
      if (j >= 11 && pulse_a) len[0]++;
      if (j >= 11 && pulse_b) len[1]++;
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (len[d] != 10) begin
        failures++;
        $display("FAIL reset_mid_pulse length gap%0d: got %0d want 10", gaps[d], len[d]);
      end
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 1500; j++) begin
      logic [WB-1:0] w;
      w = ($urandom_range(0, 39) == 0) ? 8'd255 : WB'($urandom_range(0, 12));
      tick($urandom_range(0, 63) != 0, $urandom_range(0, 2) == 0, w);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_out[d]) begin
          failures++;
          $display("FAIL random gap%0d cyc %0d: pulse/busy/done/drop got %b want %b",
                   gaps[d], cyc, obs[d], exp_out[d]);
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_acc[d] = -10;
      m_hi[d]  = -10;
      m_ok[d]  = 0;
    end
    #1;
    test_reset();
    test_single_pulse();
    test_width_bounds();
    test_trig_in_high();
    test_held_trig();
    test_reset_mid_pulse();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
